// File: rtl/fighter_pkg.sv
// fighter_pkg: state encoding and position/height widths shared by the fighter
// action engine, the renderer and the collision logic.
package fighter_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK     = 3'd1,
    CROUCH   = 3'd2,
    JUMP     = 3'd3,
    ATTACK   = 3'd4,
    PARRY    = 3'd5,
    COOLDOWN = 3'd6,
    STUN     = 3'd7
  } state_t;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic logic moving(state_t s);
    return s == WALK || s == JUMP;
  endfunction
endpackage

// File: rtl/fighter_motion.sv
// fighter_motion: move-tick divider plus saturating x position and jump height.
module fighter_motion
  import fighter_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 600,
  parameter int X_INIT   = 100,
  parameter int STEP     = 2,
  parameter int MOVE_DIV = 1000000,
  parameter int JUMP_H   = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           keep,
  input  logic           jump,
  input  logic           hit,
  input  logic           left,
  input  logic           right,
  output logic           land,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_off
);
  localparam int CW = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_DIV - 1);
  localparam logic [X_W-1:0] X_HI = X_W'(X_MAX - STEP);
  localparam logic [X_W-1:0] X_LO = X_W'(X_MIN + STEP);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic fall_q, fall_d, tick;
  // run: currently in WALK/JUMP; keep: staying there, otherwise the divider clears
  always_comb begin
    tick   = run && cnt_q == CNT_LAST;
    land   = jump && tick && fall_q && y_q == Y_W'(1);
    cnt_d  = (run && keep && !tick) ? cnt_q + 1'b1 : '0;
    x_d    = !(tick && !hit && (left ^ right)) ? x_q :
             right ? (x_q >= X_HI ? X_W'(X_MAX) : x_q + X_W'(STEP)) :
                     (x_q <= X_LO ? X_W'(X_MIN) : x_q - X_W'(STEP));
    y_d    = (hit || !jump) ? '0 : !tick ? y_q : fall_q ? y_q - 1'b1 : y_q + 1'b1;
    fall_d = (hit || !jump || land) ? 1'b0 :
             (tick && !fall_q && y_q + 1'b1 == Y_W'(JUMP_H)) ? 1'b1 : fall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      x_q    <= X_W'(X_INIT);
      y_q    <= '0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fall_q <= fall_d;
    end
  end
  assign x_pos = x_q;
  assign y_off = y_q;
endmodule

// File: rtl/fighter_action_fsm.sv
// fighter_action_fsm: per-player action engine (walk, crouch, jump, attack, parry, stun).
// Define FIGHTER_LED_DEBUG_EN to add the registered one-hot led[6:0] state output.
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 600,
  parameter int X_INIT          = 100,
  parameter int STEP            = 2,
  parameter int MOVE_DIV        = 1000000,
  parameter int JUMP_H          = 40,
  parameter int ATTACK_CYCLES   = 25000000,
  parameter int PARRY_CYCLES    = 15000000,
  parameter int COOLDOWN_CYCLES = 20000000,
  parameter int STUN_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       parry,
  input  logic       hit_in,
  output logic [9:0] x_pos,
  output logic [7:0] y_off,
  output logic [2:0] state,
  output logic       attack_active,
  output logic       parry_active,
  output logic       hit_taken,
  output logic       parry_ok
`ifdef FIGHTER_LED_DEBUG_EN
  ,
  output logic [6:0] led
`endif
);
  localparam int DUR_MAX = max2(max2(ATTACK_CYCLES, PARRY_CYCLES), max2(COOLDOWN_CYCLES, STUN_CYCLES));
  localparam int DW = $clog2(DUR_MAX + 1);
  state_t state_q, state_d;
  logic [DW-1:0] dur_q, dur_d, dur_end;
  logic attack_q, parry_q, aa_q, aa_d, pa_q, pa_d, ht_q, ht_d, po_q, po_d;
  logic atk_rise, par_rise, hit_stun, land;
  always_comb begin
    atk_rise = attack & ~attack_q;
    par_rise = parry & ~parry_q;
    hit_stun = hit_in && state_q != PARRY;
    dur_end  = state_q == ATTACK   ? DW'(ATTACK_CYCLES - 1) :
               state_q == PARRY    ? DW'(PARRY_CYCLES - 1) :
               state_q == COOLDOWN ? DW'(COOLDOWN_CYCLES - 1) : DW'(STUN_CYCLES - 1);
    state_d  = state_q;
    if (hit_stun)
      state_d = STUN;
    else
      case (state_q)
        IDLE, WALK, CROUCH:
          state_d = atk_rise ? ATTACK : par_rise ? PARRY : up ? JUMP : down ? CROUCH :
                    (left ^ right) ? WALK : IDLE;
        JUMP:     state_d = land ? IDLE : JUMP;
        ATTACK:   state_d = dur_q == dur_end ? COOLDOWN : ATTACK;
        PARRY:    state_d = dur_q == dur_end ? COOLDOWN : PARRY;
        default:  state_d = dur_q == dur_end ? IDLE : state_q;
      endcase
    // a hit in STUN re-enters STUN, so the shared counter restarts too
    dur_d = (hit_stun || state_d != state_q || state_q < ATTACK) ? '0 : dur_q + 1'b1;
    aa_d  = state_d == ATTACK;
    pa_d  = state_d == PARRY;
    ht_d  = hit_stun;
    po_d  = hit_in && state_q == PARRY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dur_q    <= '0;
      attack_q <= 1'b0;
      parry_q  <= 1'b0;
      aa_q     <= 1'b0;
      pa_q     <= 1'b0;
      ht_q     <= 1'b0;
      po_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dur_q    <= dur_d;
      attack_q <= attack;
      parry_q  <= parry;
      aa_q     <= aa_d;
      pa_q     <= pa_d;
      ht_q     <= ht_d;
      po_q     <= po_d;
    end
  end
  fighter_motion #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .STEP(STEP),
    .MOVE_DIV(MOVE_DIV), .JUMP_H(JUMP_H)
  ) u_motion (
    .clk(clk), .rst_n(rst_n),
    .run(moving(state_q)), .keep(moving(state_d)), .jump(state_q == JUMP), .hit(hit_stun),
    .left(left), .right(right), .land(land), .x_pos(x_pos), .y_off(y_off)
  );
  assign state         = state_q;
  assign attack_active = aa_q;
  assign parry_active  = pa_q;
  assign hit_taken     = ht_q;
  assign parry_ok      = po_q;
`ifdef FIGHTER_LED_DEBUG_EN
  logic [6:0] led_q, led_d;
  logic [7:0] oh;
  always_comb begin
    oh    = 8'b1 << state_d;
    led_d = oh[7:1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end
  assign led = led_q;
`endif
endmodule

// File: tb/tb_fighter_action_fsm.sv
// tb_fighter_action_fsm: scoreboard bench for the fighter action engine with shortened timings.
module tb_fighter_action_fsm;
  import fighter_pkg::*;
  typedef struct packed {
    logic [2:0] st;
    logic [9:0] x;
    logic [7:0] y;
    logic aa;
    logic pa;
    logic ht;
    logic po;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic left = 0, right = 0, up = 0, down = 0, attack = 0, parry = 0, hit_in = 0;
  logic [9:0] x_pos;
  logic [7:0] y_off;
  logic [2:0] state;
  logic attack_active, parry_active, hit_taken, parry_ok;
`ifdef FIGHTER_LED_DEBUG_EN
  logic [6:0] led;
`endif
  obs_t exp_q[$];
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  fighter_action_fsm #(
    .MOVE_DIV(4), .STEP(2), .JUMP_H(3), .ATTACK_CYCLES(8), .PARRY_CYCLES(6),
    .COOLDOWN_CYCLES(5), .STUN_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .up(up), .down(down),
    .attack(attack), .parry(parry), .hit_in(hit_in), .x_pos(x_pos), .y_off(y_off),
    .state(state), .attack_active(attack_active), .parry_active(parry_active),
    .hit_taken(hit_taken), .parry_ok(parry_ok)
`ifdef FIGHTER_LED_DEBUG_EN
    , .led(led)
`endif
  );

  function automatic obs_t mk(state_t s, int x, int y, logic aa, logic pa, logic ht, logic po);
    return {s, 10'(x), 8'(y), aa, pa, ht, po};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {left, right, up, down, attack, parry, hit_in} = '0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    do_reset();
    exp_q.push_back(mk(IDLE, 100, 0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
               got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
    end
  endtask

  task automatic test_walk();
    obs_t e, got;
    do_reset();
    right = 1;
    for (int k = 1; k <= 21; k++) begin
      if (k == 18) left = 1;
      exp_q.push_back(k <= 17 ? mk(WALK, 100 + 2 * (k >= 5 ? (k - 1) / 4 : 0), 0, 0, 0, 0, 0)
                              : mk(IDLE, 108, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL walk k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    {left, right} = '0;
  endtask

  task automatic test_saturate();
    obs_t e, got;
    int runs[5] = '{997, 4, 8, 1196, 16};
    int xs[5] = '{598, 600, 600, 2, 0};
    do_reset();
    right = 1;
    for (int p = 0; p < 5; p++) begin
      if (p == 3) {left, right} = 2'b10;
      exp_q.push_back(mk(WALK, xs[p], 0, 0, 0, 0, 0));
      repeat (runs[p]) step();
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL saturate p=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 p, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    {left, right} = '0;
  endtask

  task automatic test_attack();
    obs_t e, got;
    do_reset();
    attack = 1;
    for (int k = 1; k <= 42; k++) begin
      if (k == 41) attack = 0;
      if (k == 42) attack = 1;
      exp_q.push_back(k == 42 ? mk(ATTACK, 100, 0, 1, 0, 0, 0) :
                      k <= 8  ? mk(ATTACK, 100, 0, 1, 0, 0, 0) :
                      k <= 13 ? mk(COOLDOWN, 100, 0, 0, 0, 0, 0) : mk(IDLE, 100, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL attack k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    attack = 0;
  endtask

  task automatic test_parry();
    obs_t e, got;
    do_reset();
    parry = 1;
    for (int k = 1; k <= 12; k++) begin
      hit_in = (k == 4);
      exp_q.push_back(k <= 6  ? mk(PARRY, 100, 0, 0, 1, 0, k == 4) :
                      k <= 11 ? mk(COOLDOWN, 100, 0, 0, 0, 0, 0) : mk(IDLE, 100, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL parry k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    {parry, hit_in} = '0;
  endtask

  task automatic test_jump();
    obs_t e, got;
    int y;
    do_reset();
    up = 1;
    for (int k = 1; k <= 26; k++) begin
      y = k < 5 ? 0 : k < 9 ? 1 : k < 13 ? 2 : k < 17 ? 3 : k < 21 ? 2 : k < 25 ? 1 : 0;
      exp_q.push_back(mk(k <= 24 ? JUMP : IDLE, 100, y, 0, 0, 0, 0));
      step();
      up = 0;
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL jump k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
  endtask

  task automatic test_hit_stun();
    obs_t e, got;
    do_reset();
    up = 1;
    step();
    up = 0;
    repeat (9) step();
    exp_q.push_back(mk(JUMP, 100, 2, 0, 0, 0, 0));
    // hits at k=1 (mid-jump) and k=6 (inside STUN, restarts the stun)
    for (int k = 0; k <= 16; k++) begin
      hit_in = (k == 1 || k == 6);
      if (k > 0) begin
        exp_q.push_back(mk(k <= 15 ? STUN : IDLE, 100, 0, 0, 0, hit_in, 0));
        step();
      end
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL hit_stun k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    hit_in = 0;
  endtask

  task automatic test_reset_abort();
    obs_t e, got;
    do_reset();
    attack = 1;
    repeat (3) step();
    exp_q.push_back(mk(ATTACK, 100, 0, 1, 0, 0, 0));
    for (int k = 0; k <= 12; k++) begin
      if (k == 1) begin
        #2;
        rst_n = 0;
        #1;
        exp_q.push_back(mk(IDLE, 100, 0, 0, 0, 0, 0));
      end
      if (k == 2) begin
        attack = 0;
        step();
        rst_n = 1;
        {attack, hit_in} = 2'b11;
      end
      if (k >= 2) begin
        exp_q.push_back(mk(k <= 11 ? STUN : IDLE, 100, 0, 0, 0, k == 2, 0));
        step();
        hit_in = 0;
      end
      e = exp_q.pop_front();
      got = {state, x_pos, y_off, attack_active, parry_active, hit_taken, parry_ok};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_abort k=%0d: got st=%0d x=%0d y=%0d flags=%b, expected st=%0d x=%0d y=%0d flags=%b",
                 k, got.st, got.x, got.y, got[3:0], e.st, e.x, e.y, e[3:0]);
      end
    end
    attack = 0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_saturate();
    test_attack();
    test_parry();
    test_jump();
    test_hit_stun();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end
endmodule
